seq_divider: RTL and testbench

Iterative 32-bit restoring divider for the execute stage. It sits directly upstream of the carry look-ahead adder: each cycle it drives the adder's operands in subtract mode and consumes the sum and carry-out to build the quotient one bit at a time. It returns the quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics and uses a start/busy/done handshake.

---
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider (RISC-V DIV/DIVU/REM/REMU) driving an external adder in subtract mode.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_mode,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem_r;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dz_pending;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             divisor_zero;
    logic [WIDTH:0]   s;
    logic             accept;

`ifdef DIV_SIGNED_EN
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
`endif

    assign divisor_zero = (divisor == '0);
    assign s            = {rem_r, dvd_mag[WIDTH-1]};
    assign accept       = s[WIDTH] | add_cout;

    // Adder is only exercised while dividing; otherwise all drives sit at zero.
    assign add_a    = (state == DIVIDE) ? s[WIDTH-1:0] : '0;
    assign add_b    = (state == DIVIDE) ? dvs_mag : '0;
    assign add_cin  = (state == DIVIDE);
    assign add_mode = (state == DIVIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dvd_mag     <= '0;
            dvs_mag     <= '0;
            rem_r       <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_pending  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // On divide-by-zero the raw dividend is kept so it can be returned unchanged.
                        dvd_mag    <= (dvd_neg && !divisor_zero) ? (~dividend + WIDTH'(1)) : dividend;
                        dvs_mag    <= dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
                        q_neg      <= dvd_neg ^ dvs_neg;
                        r_neg      <= dvd_neg;
                        rem_r      <= '0;
                        cnt        <= '0;
                        dz_pending <= divisor_zero;
                        busy       <= 1'b1;
                        state      <= divisor_zero ? FIX : DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_r   <= accept ? add_sum : s[WIDTH-1:0];
                    dvd_mag <= {dvd_mag[WIDTH-2:0], accept};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz_pending) begin
                        quotient    <= '1;
                        remainder   <= dvd_mag;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_neg ? (~dvd_mag + WIDTH'(1)) : dvd_mag;
                        remainder   <= r_neg ? (~rem_r + WIDTH'(1)) : rem_r;
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; signed expectations follow DIV_SIGNED_EN.
module tb_seq_divider;

    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst, start, is_signed;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_mode, add_cout;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .is_signed(is_signed), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_mode(add_mode), .add_sum(add_sum), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, (add_mode ? ~add_b : add_b)} + 33'(add_cin);

    localparam logic [31:0] U_A [5] = '{32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1000000, 32'd12345};
    localparam logic [31:0] U_B [5] = '{32'd7,   32'd1,        32'h80000000, 32'd1000,    32'd12346};
    localparam logic [31:0] U_Q [5] = '{32'd14,  32'hFFFFFFFF, 32'd1,        32'd1000,    32'd0};
    localparam logic [31:0] U_R [5] = '{32'd2,   32'd0,        32'h7FFFFFFF, 32'd0,       32'd12345};

    localparam logic [31:0] S_A [5] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFF9};
    localparam logic [31:0] S_B [5] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2};
    localparam logic        S_S [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef DIV_SIGNED_EN
    localparam logic [31:0] S_Q [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'h7FFFFFFC};
    localparam logic [31:0] S_R [5] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1};
`else
    localparam logic [31:0] S_Q [5] = '{32'h7FFFFFFC, 32'd0, 32'd0, 32'd0, 32'h7FFFFFFC};
    localparam logic [31:0] S_R [5] = '{32'd1, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd1};
`endif

    // Present operands with start for one cycle; returns just after the sampling edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the start cycle until done is seen, bounded.
    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #1;
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
        end
        n_vec++;
        if ({quotient, remainder} !== 64'd0) begin
            n_err++; $display("FAIL reset_results got q=%h r=%h want 0/0", quotient, remainder);
        end
        n_vec++;
        if ({add_a, add_b, add_cin, add_mode} !== 66'd0) begin
            n_err++; $display("FAIL reset_adder got a=%h b=%h cin=%b mode=%b want zeros", add_a, add_b, add_cin, add_mode);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            launch(U_A[i], U_B[i], 1'b0);
            wait_done(1, cyc);
            n_vec++;
            if (cyc !== 34) begin
                n_err++; $display("FAIL unsigned[%0d]_latency got %0d want 34", i, cyc);
            end
            n_vec++;
            if (quotient !== U_Q[i] || remainder !== U_R[i] || div_by_zero !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL unsigned[%0d] got q=%h r=%h dz=%b busy=%b want q=%h r=%h dz=0 busy=0",
                         i, quotient, remainder, div_by_zero, busy, U_Q[i], U_R[i]);
            end
        end
    endtask

    task automatic test_adder_drive;
        int cyc;
        launch(32'd100, 32'd7, 1'b0);
        n_vec++;
        if (add_a !== 32'd0 || add_b !== 32'd7 || add_cin !== 1'b1 || add_mode !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL adder_first got a=%h b=%h cin=%b mode=%b busy=%b want 0/7/1/1/1",
                     add_a, add_b, add_cin, add_mode, busy);
        end
        repeat (28) @(negedge clk);
        // Partial remainder 6, next dividend bit 0 -> S=12, subtract gives 5 without borrow
        n_vec++;
        if (add_a !== 32'd12 || add_sum !== 32'd5 || add_cout !== 1'b1) begin
            n_err++; $display("FAIL adder_step got a=%h sum=%h cout=%b want 0c/5/1", add_a, add_sum, add_cout);
        end
        wait_done(29, cyc);
        n_vec++;
        if (cyc !== 34 || quotient !== 32'd14 || remainder !== 32'd2) begin
            n_err++; $display("FAIL adder_result got cyc=%0d q=%h r=%h want 34/e/2", cyc, quotient, remainder);
        end
    endtask

    task automatic test_signed;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            launch(S_A[i], S_B[i], S_S[i]);
            wait_done(1, cyc);
            n_vec++;
            if (cyc !== 34 || quotient !== S_Q[i] || remainder !== S_R[i] || div_by_zero !== 1'b0) begin
                n_err++;
                $display("FAIL signed[%0d] got cyc=%0d q=%h r=%h dz=%b want cyc=34 q=%h r=%h dz=0",
                         i, cyc, quotient, remainder, div_by_zero, S_Q[i], S_R[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int   cyc;
        logic ports_bad;
        logic [31:0] dz_a [2] = '{32'd5, 32'hFFFFFFFB};
        for (int i = 0; i < 2; i++) begin
            launch(dz_a[i], 32'd0, 1'b1);
            cyc = 1;
            ports_bad = 1'b0;
            while (done !== 1'b1 && cyc < 100) begin
                if ({add_a, add_b, add_cin, add_mode} !== 66'd0) ports_bad = 1'b1;
                @(negedge clk);
                cyc++;
            end
            n_vec++;
            if (cyc !== 2) begin
                n_err++; $display("FAIL dz[%0d]_latency got %0d want 2", i, cyc);
            end
            n_vec++;
            if (quotient !== 32'hFFFFFFFF || remainder !== dz_a[i] || div_by_zero !== 1'b1) begin
                n_err++;
                $display("FAIL dz[%0d] got q=%h r=%h dz=%b want ffffffff/%h/1", i, quotient, remainder, div_by_zero, dz_a[i]);
            end
            n_vec++;
            if (ports_bad !== 1'b0) begin
                n_err++; $display("FAIL dz[%0d]_adder got nonzero drive want all zero", i);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 32'hFFFFFFFF) begin
                n_err++; $display("FAIL dz[%0d]_hold got done=%b dz=%b q=%h want 0/1/ffffffff", i, done, div_by_zero, quotient);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 32'd100; divisor = 32'd7;
        wait_done(11, cyc);
        n_vec++;
        if (cyc !== 34 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            n_err++; $display("FAIL ignore_start got cyc=%0d q=%h r=%h dz=%b want 34/e/2/0", cyc, quotient, remainder, div_by_zero);
        end
        // start held through the DONE cycle: ignored there, accepted on the following edge
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL start_in_done got busy=%b done=%b want 0/0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL restart_accept got busy=%b want 1", busy);
        end
        wait_done(1, cyc);
        n_vec++;
        if (cyc !== 34 || quotient !== 32'd3 || remainder !== 32'd0) begin
            n_err++; $display("FAIL restart_result got cyc=%0d q=%h r=%h want 34/3/0", cyc, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc;
        launch(32'd100, 32'd7, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        n_vec++;
        if ({add_a, add_b, add_cin, add_mode} !== 66'd0) begin
            n_err++; $display("FAIL mid_reset_adder got a=%h b=%h cin=%b mode=%b want zeros", add_a, add_b, add_cin, add_mode);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(32'd9, 32'd3, 1'b0);
        wait_done(1, cyc);
        n_vec++;
        if (cyc !== 34 || quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            n_err++; $display("FAIL post_reset got cyc=%0d q=%h r=%h dz=%b want 34/3/0/0", cyc, quotient, remainder, div_by_zero);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_adder_drive();
        test_signed();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
